// File: rtl/mas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mas_pkg
// Brief    : Shared types and helpers for the memory address sequencer.
// Revision : 1.0
// ============================================================================
package mas_pkg;

    typedef enum logic [0:0] {
        MAS_IDLE  = 1'b0,
        MAS_BURST = 1'b1
    } mas_state_t;

    // Width of the byte-offset field that must be zero for an aligned address.
    function automatic int mas_off_w(input int unsigned beat_bytes);
        return $clog2(beat_bytes);
    endfunction

    function automatic int unsigned mas_sat_len(input int unsigned len,
                                                input int unsigned max_beats);
        return (len > max_beats) ? max_beats : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mas_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mas_beat_counter
// Brief    : Loadable down-counter of remaining burst beats with last flag.
// Revision : 1.0
// ============================================================================
module mas_beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [LEN_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign last = (r_count == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_address_sequencer
// Brief    : Address register with write-through bypass and strided bursts.
// Revision : 1.0
// ============================================================================
module mem_address_sequencer
    import mas_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 4,
    parameter int MAX_BEATS  = 8,
    parameter int LEN_W      = $clog2(MAX_BEATS) + 1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic              mas_clk,
    input  logic              mas_rst,
    input  logic [ADDR_W-1:0] mas_in,
    input  logic              mas_wr_en,
    input  logic [LEN_W-1:0]  mas_len,
    input  logic              mas_start,
    input  logic              mas_beat_ack,
    input  logic              mas_abort,
    output logic [ADDR_W-1:0] mas_out,
    output logic              mas_valid,
    output logic              mas_busy,
    output logic              mas_done,
    output logic              mas_err,
    output logic              mas_misaligned
);

    localparam int OFF_W = mas_off_w(BEAT_BYTES);

    mas_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_err;

    logic              w_idle;
    logic              w_bypass;
    logic [ADDR_W-1:0] w_eff;
    logic              w_mis;
    logic [LEN_W-1:0]  w_len_sat;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_beat;
    logic              w_last;

    assign w_idle   = (r_state == MAS_IDLE);
    assign w_bypass = BYPASS && w_idle && mas_wr_en;
    assign w_eff    = w_bypass ? mas_in : r_addr;

    generate
        if (OFF_W > 0) begin : g_align
            assign w_mis = |w_eff[OFF_W-1:0];
        end else begin : g_no_align
            assign w_mis = 1'b0;
        end
    endgenerate

    assign w_len_sat   = LEN_W'(mas_sat_len(int'(mas_len), MAX_BEATS));
    assign w_start_bad = w_idle && mas_start && (w_mis || (mas_len == '0));
    assign w_start_ok  = w_idle && mas_start && !w_mis && (mas_len != '0);
    // An abort in the same cycle as an ack swallows that beat.
    assign w_beat      = !w_idle && mas_beat_ack && !mas_abort;

    mas_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk      (mas_clk),
        .rst      (mas_rst),
        .load     (w_start_ok),
        .load_val (w_len_sat),
        .dec      (w_beat),
        .last     (w_last)
    );

    always_ff @(posedge mas_clk or posedge mas_rst) begin
        if (mas_rst) begin
            r_state <= MAS_IDLE;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                MAS_IDLE: begin
                    if (mas_wr_en) r_addr <= mas_in;
                    if (w_start_bad) r_err <= 1'b1;
                    else if (w_start_ok) r_state <= MAS_BURST;
                end
                MAS_BURST: begin
                    if (mas_abort) begin
                        r_state <= MAS_IDLE;
                    end else if (mas_beat_ack) begin
                        r_addr <= r_addr + ADDR_W'(BEAT_BYTES);
                        if (w_last) begin
                            r_state <= MAS_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= MAS_IDLE;
            endcase
        end
    end

    assign mas_out        = w_eff;
    assign mas_valid      = (r_state == MAS_BURST);
    assign mas_busy       = (r_state == MAS_BURST);
    assign mas_done       = r_done;
    assign mas_err        = r_err;
    assign mas_misaligned = w_mis;

endmodule
`default_nettype wire

// File: tb/tb_mem_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_address_sequencer
// Brief    : Directed bench with a queue-based burst model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_mem_address_sequencer;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      a_in;
    logic             wr_en;
    logic [LEN_W-1:0] len;
    logic             start;
    logic             ack;
    logic             abort;
    logic [31:0]      a_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             mis;

    int checks = 0;
    int errors = 0;

    mem_address_sequencer #(
        .ADDR_W     (32),
        .BEAT_BYTES (4),
        .MAX_BEATS  (8),
        .LEN_W      (LEN_W),
        .BYPASS     (1'b1)
    ) dut (
        .mas_clk        (clk),
        .mas_rst        (rst),
        .mas_in         (a_in),
        .mas_wr_en      (wr_en),
        .mas_len        (len),
        .mas_start      (start),
        .mas_beat_ack   (ack),
        .mas_abort      (abort),
        .mas_out        (a_out),
        .mas_valid      (valid),
        .mas_busy       (busy),
        .mas_done       (done),
        .mas_err        (err),
        .mas_misaligned (mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start expands into the list of beat addresses still owed.
    logic [31:0] m_addr;
    logic [31:0] m_q[$];
    logic        m_done;
    logic        m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr = 32'h0;
            m_q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            logic [31:0] eff;
            int unsigned n;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_q.size() != 0) begin
                if (abort) begin
                    m_addr = m_q[0];
                    m_q.delete();
                end else if (ack) begin
                    m_addr = m_q[0] + 32'd4;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end
            end else begin
                eff = wr_en ? a_in : m_addr;
                if (start) begin
                    if (eff[1:0] != 2'b00 || len == 0) begin
                        m_err = 1'b1;
                    end else begin
                        n = (len > 8) ? 8 : len;
                        for (int i = 0; i < int'(n); i++) m_q.push_back(eff + 32'(4 * i));
                    end
                end
                if (wr_en) m_addr = a_in;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic        b_e;
            logic [31:0] o_e;
            b_e = (m_q.size() != 0);
            o_e = b_e ? m_q[0] : (wr_en ? a_in : m_addr);
            chk("cyc_out",   a_out, o_e);
            chk("cyc_valid", {31'b0, valid}, {31'b0, b_e});
            chk("cyc_busy",  {31'b0, busy},  {31'b0, b_e});
            chk("cyc_done",  {31'b0, done},  {31'b0, m_done});
            chk("cyc_err",   {31'b0, err},   {31'b0, m_err});
            chk("cyc_mis",   {31'b0, mis},   {31'b0, (o_e[1:0] != 2'b00)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; start = 0; ack = 0; abort = 0; len = '0; a_in = '0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_inputs();
        #12;
        chk("rst_out",   a_out, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        rst = 1'b0;
        tick();

        // Plain load then a 3-beat burst with ack every cycle.
        wr_en = 1; a_in = 32'h1000;
        tick();
        wr_en = 0; start = 1; len = 3;
        tick();
        start = 0; ack = 1;
        chk("b1_beat0", a_out, 32'h1000);
        chk("b1_valid", {31'b0, valid}, 32'h1);
        tick(); chk("b1_beat1", a_out, 32'h1004);
        tick(); chk("b1_beat2", a_out, 32'h1008);
        tick(); ack = 0;
        chk("b1_done", {31'b0, done}, 32'h1);
        chk("b1_busy", {31'b0, busy}, 32'h0);
        chk("b1_reg",  a_out, 32'h100C);
        tick(); chk("b1_done_once", {31'b0, done}, 32'h0);

        // Load and start together, with a stalled first beat.
        wr_en = 1; a_in = 32'h2000; start = 1; len = 2;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("b2_stall", a_out, 32'h2000);
            tick();
        end
        ack = 1;
        tick(); chk("b2_beat1", a_out, 32'h2004);
        tick(); ack = 0;
        chk("b2_done", {31'b0, done}, 32'h1);

        // Rejected starts: misaligned address, then zero length.
        wr_en = 1; a_in = 32'h3002; start = 1; len = 2;
        #1; chk("b3_mis", {31'b0, mis}, 32'h1);
        tick(); idle_inputs();
        chk("b3_err",  {31'b0, err},  32'h1);
        chk("b3_busy", {31'b0, busy}, 32'h0);
        wr_en = 1; a_in = 32'h3000; start = 1; len = 0;
        tick(); idle_inputs();
        chk("b3_err_len0", {31'b0, err}, 32'h1);
        tick(); chk("b3_err_clear", {31'b0, err}, 32'h0);

        // Address wrap across the top of the space.
        wr_en = 1; a_in = 32'hFFFF_FFF8; start = 1; len = 4;
        tick(); idle_inputs(); ack = 1;
        chk("b4_beat0", a_out, 32'hFFFF_FFF8);
        tick(); chk("b4_beat1", a_out, 32'hFFFF_FFFC);
        tick(); chk("b4_beat2", a_out, 32'h0000_0000);
        tick(); chk("b4_beat3", a_out, 32'h0000_0004);
        tick(); ack = 0;
        chk("b4_done", {31'b0, done}, 32'h1);

        // Over-long request saturates at MAX_BEATS, continuing from 0x8.
        start = 1; len = 15;
        tick(); start = 0; len = 0; ack = 1;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        ack = 0;
        chk("b5_beats", 32'(n), 32'd8);
        chk("b5_done",  {31'b0, done}, 32'h1);
        chk("b5_reg",   a_out, 32'h28);

        // Abort coinciding with the third ack.
        wr_en = 1; a_in = 32'h4000; start = 1; len = 5;
        tick(); idle_inputs(); ack = 1;
        tick(); tick();
        abort = 1;
        tick(); idle_inputs();
        chk("b6_busy", {31'b0, busy}, 32'h0);
        chk("b6_done", {31'b0, done}, 32'h0);
        chk("b6_reg",  a_out, 32'h4008);

        // Asynchronous reset in the middle of a burst.
        start = 1; len = 3;
        tick(); idle_inputs();
        chk("b7_busy", {31'b0, busy}, 32'h1);
        #3; rst = 1'b1;
        #1;
        chk("b7_rst_out",   a_out, 32'h0);
        chk("b7_rst_valid", {31'b0, valid}, 32'h0);
        chk("b7_rst_busy",  {31'b0, busy},  32'h0);
        #10; rst = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_address_sequencer.md
Name: mem_address_sequencer

Overview:
- Parametrised successor to the single-register memory address latch.
- Holds a memory address with the same load and write-through bypass behaviour.
- Adds stride-based auto-increment bursts driven by a small FSM, a beat handshake with the memory port, an alignment check, and abort.
- Sits between the control unit and the data-memory interface: it generates the address sequence for multi-beat loads and stores.

Parameters:
- ADDR_W, 32: address width in bits.
- BEAT_BYTES, 4: bytes per beat. This is the increment stride and must be a power of 2, at least 1.
- MAX_BEATS, 8: maximum burst length in beats; at least 1.
- LEN_W, $clog2(MAX_BEATS)+1: width of the length input (derived).
- BYPASS, 1: when 1, mas_out shows mas_in combinationally during a load.

Ports:
- mas_clk  in  1  clock; all state updates on the rising edge.
- mas_rst  in  1  reset, asynchronous, active-high.
- mas_in  in  ADDR_W  address to load.
- mas_wr_en  in  1  load the address register (accepted in IDLE only).
- mas_len  in  LEN_W  burst length in beats; sampled on start.
- mas_start  in  1  begin a burst at the current (or simultaneously loaded) address.
- mas_beat_ack  in  1  memory accepted the current beat.
- mas_abort  in  1  terminate the burst.
- mas_out  out  ADDR_W  current address to memory.
- mas_valid  out  1  mas_out is a live burst beat.
- mas_busy  out  1  FSM is in BURST.
- mas_done  out  1  one-cycle pulse when a burst completes normally.
- mas_err  out  1  one-cycle pulse when a start is rejected.
- mas_misaligned  out  1  combinational: the effective address has nonzero bits in [$clog2(BEAT_BYTES)-1:0]. Constant 0 when BEAT_BYTES=1.

Behaviour:
- Reset, asynchronous: address register = 0, remaining-beat counter = 0, state = IDLE, mas_done = 0, mas_err = 0. Therefore mas_out = 0 (unless bypassing), mas_valid = 0, mas_busy = 0.
- Effective address: mas_in when BYPASS=1 and mas_wr_en is high in IDLE; otherwise the address register.
- mas_out = effective address. mas_misaligned is evaluated on the effective address.
- States: IDLE, BURST.
- IDLE:
  - mas_wr_en high: address register <= mas_in at the next edge.
  - mas_start high: evaluated against the effective address, so start and wr_en in the same cycle burst from mas_in.
  - Start is rejected if the effective address is misaligned or mas_len == 0. Rejection gives mas_err = 1 for the next cycle and the state stays IDLE; the address is still loaded if wr_en is high.
  - mas_len > MAX_BEATS saturates to MAX_BEATS.
  - Accepted start: remaining <= length, state <= BURST.
- BURST:
  - mas_valid = 1, mas_busy = 1, mas_out = address register. The bypass path is inactive.
  - mas_wr_en and mas_start are ignored.
  - On mas_beat_ack: address <= address + BEAT_BYTES, wrapping modulo 2^ADDR_W with no flag; remaining <= remaining - 1.
  - Ack with remaining == 1: state <= IDLE and mas_done = 1 for the next cycle.
  - mas_valid stays high until ack; the address must not change without ack.
- Abort:
  - mas_abort in BURST: state <= IDLE next edge; no done pulse; the address register keeps its value.
  - abort has priority over beat_ack in the same cycle, so that beat is not counted.
  - mas_abort in IDLE has no effect.
- Post-increment: after a burst the register holds last beat + BEAT_BYTES, so back-to-back starts continue sequentially.
- Throughput: a new start is accepted in the cycle immediately after done (the done cycle is IDLE).
- mas_done and mas_err are registered and never high together.

Decomposition:
- Package mas_pkg:
  - state enum {MAS_IDLE, MAS_BURST};
  - localparam OFF_W = $clog2(BEAT_BYTES) for the alignment mask;
  - length-saturation function.
- Sub-module mas_beat_counter: loadable down-counter of LEN_W bits with load, decrement and last (== 1) outputs; asynchronous active-high reset.
- The FSM and the address register live in the top level.

Test Plan:
- Reset, then load 0x0000_1000 and start with len = 3; ack every cycle → mas_out 0x1000, 0x1004, 0x1008 with valid = 1. Then done pulses once, busy = 0, and the register holds 0x100C.
- wr_en with mas_in = 0x2000 and start in the same cycle, len = 2; ack held low for 3 cycles, then pulsed → mas_out holds 0x2000 while stalled, then 0x2004; done follows the second ack.
- Load 0x0000_3002 and start → mas_misaligned = 1, mas_err pulses, busy stays 0. Then start with len = 0 at 0x3000 → err pulses.
- Load 0xFFFF_FFF8 and start with len = 4 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004; done pulses.
- Start with len = 15 (MAX_BEATS = 8) → exactly 8 beats.
- Start with len = 5; after 2 acks assert abort together with ack → returns to IDLE, no done, register = base + 8. Finally, assert mas_rst asynchronously mid-burst → outputs 0 immediately, with no clock edge.
